// File: rtl/entropy_word_packer_pkg.sv
// Shared parameters for the entropy path: the health-test constants and the
// word packer / FIFO geometry used downstream of the health test.
package entropy_word_packer_pkg;

  // Health-test window length and repetition cutoff, kept here so every block
  // in the entropy path pulls them from one place.
  localparam int ENTROPY_SAMPLE = 1024;
  localparam int C_PERM         = 40;

  // Packer geometry: bits per word and number of buffered words.
  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/entropy_fifo.sv
// Small synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   push, din    write din when push is high and the FIFO is not full
//   pop          drop the head word when pop is high and the FIFO is not empty
//   flush        empty the FIFO (pointers and level to zero); beats push/pop
//   dout         head word, mem[rd_ptr], valid whenever !empty
//   level        number of stored words (0..DEPTH)
//   empty, full  level == 0 / level == DEPTH
module entropy_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WORD_W-1:0]          din,
  output logic [WORD_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_en;
  logic              pop_en;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap modulo DEPTH on their own; level is kept separately so a
  // full FIFO is distinguishable from an empty one.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; the head word is only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (push_en && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/entropy_word_packer.sv
// Packs the health-tested entropy bit stream (one bit per cycle) into WORD_W
// bit words, first accepted bit at the MSB, and buffers completed words in an
// entropy_fifo toward the conditioner.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bit_in      raw entropy bit
//   bit_valid   bit_in is offered this cycle
//   perm_fail   permanent health failure: drop everything, set err
//   full        buffer cannot take bits (also high while err)
//   word_out    head word (zero while no word is valid)
//   word_valid  word_out holds a word
//   word_ready  consumer takes word_out this cycle
//   level       number of buffered words
//   err         sticky permanent-failure flag, cleared only by rst
module entropy_word_packer
  import entropy_word_packer_pkg::*;
#(
  parameter int WORD_W = entropy_word_packer_pkg::WORD_W,
  parameter int DEPTH  = entropy_word_packer_pkg::FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   perm_fail,
  output logic                   full,
  output logic [WORD_W-1:0]      word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] next_word;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              acc;
  logic              push;
  logic              pop;

  // Both terms of full come straight from registers (err and the FIFO level).
  assign full       = err || fifo_full;
  assign word_valid = !err && !fifo_empty;
  assign word_out   = word_valid ? fifo_dout : '0;

  // perm_fail blocks the accept and the pop in its own cycle and flushes.
  assign acc       = bit_valid && !full && !err && !perm_fail;
  assign next_word = {shreg[WORD_W-2:0], bit_in};
  assign push      = acc && (bit_cnt == CNT_W'(WORD_W - 1));
  assign pop       = word_valid && word_ready && !perm_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      err     <= 1'b0;
    end else if (perm_fail) begin
      shreg   <= '0;
      bit_cnt <= '0;
      err     <= 1'b1;
    end else if (acc) begin
      shreg   <= next_word;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  entropy_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (perm_fail),
    .din   (next_word),
    .dout  (fifo_dout),
    .level (level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_entropy_word_packer.sv
// Self-checking bench for entropy_word_packer: a queue-based model of the
// packer checked against the DUT every cycle, plus directed scenarios with
// hand-computed literal expectations.
module tb_entropy_word_packer;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          perm_fail;
  logic          full;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic          word_ready;
  logic [2:0]    level;
  logic          err;

  int error_count = 0;
  int check_count = 0;
  bit checking_on = 1'b0;

  // Model state: buffered words, partial word and its bit count, sticky error.
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_word;
  int           model_bits;
  bit           model_err;

  logic [W-1:0] w [0:8];

  entropy_word_packer dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .perm_fail  (perm_fail),
    .full       (full),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .level      (level),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    bit m_full;
    bit m_acc;
    bit m_pop;
    if (rst) begin
      model_q.delete();
      model_word = '0;
      model_bits = 0;
      model_err  = 1'b0;
    end else if (perm_fail) begin
      model_q.delete();
      model_word = '0;
      model_bits = 0;
      model_err  = 1'b1;
    end else begin
      m_full = model_err || (model_q.size() == D);
      m_acc  = bit_valid && !m_full;
      m_pop  = !model_err && (model_q.size() > 0) && word_ready;
      if (m_pop) void'(model_q.pop_front());
      if (m_acc) begin
        model_word = {model_word[W-2:0], bit_in};
        model_bits = model_bits + 1;
        if (model_bits == W) begin
          model_q.push_back(model_word);
          model_bits = 0;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (checking_on) begin
      check_output("model.level", W'(level), W'(model_q.size()));
      check_output("model.err", W'(err), W'(model_err));
      check_output("model.full", W'(full), W'(model_err || model_q.size() == D));
      check_output("model.word_valid", W'(word_valid), W'(!model_err && model_q.size() > 0));
      if (!model_err && model_q.size() > 0)
        check_output("model.word_out", word_out, model_q[0]);
    end
  end

  task automatic apply_stimulus(input logic b, input logic v, input logic r,
                                input logic p, input logic rs);
    bit_in     = b;
    bit_valid  = v;
    word_ready = r;
    perm_fail  = p;
    rst        = rs;
    @(posedge clk);
    #2;
  endtask

  // Offer the top n bits of word, MSB first, one per cycle.
  task automatic send_bits(input logic [W-1:0] word, input int n, input logic r);
    for (int i = 0; i < n; i++) apply_stimulus(word[W-1-i], 1'b1, r, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] word, input logic r);
    send_bits(word, W, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".full"}, W'(full), '0);
    check_output({tag, ".word_valid"}, W'(word_valid), '0);
    check_output({tag, ".word_out"}, word_out, '0);
    check_output({tag, ".level"}, W'(level), '0);
    check_output({tag, ".err"}, W'(err), '0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] toggle_word;
    w[0] = 32'h1234_5670; w[1] = 32'h8000_0001; w[2] = 32'hDEAD_BEEF;
    w[3] = 32'h0F1E_2D3C; w[4] = 32'hFFFF_0000; w[5] = 32'h1357_9BDF;
    w[6] = 32'h2468_ACE0; w[7] = 32'hC001_D00D; w[8] = 32'h5555_AAAA;

    bit_in = 0; bit_valid = 0; word_ready = 0; perm_fail = 0; rst = 1;
    #2;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checking_on = 1'b1;
    check_reset_values("reset");

    // First word: valid one cycle after the 32nd bit.
    send_word(32'hA5A5_0F0F, 1'b0);
    check_output("first.word_valid", W'(word_valid), 1);
    check_output("first.word_out", word_out, 32'hA5A5_0F0F);
    check_output("first.level", W'(level), 1);
    check_output("first.model_head", model_q[0], 32'hA5A5_0F0F);
    pop_one();
    check_output("first.popped_level", W'(level), 0);

    // Fill to DEPTH, then the next bit must be held.
    for (int k = 0; k < 4; k++) send_word(w[k], 1'b0);
    check_output("fill.level", W'(level), 4);
    check_output("fill.full", W'(full), 1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("fill.held_level", W'(level), 4);
    check_output("fill.head", word_out, w[0]);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("fill.after_pop_full", W'(full), 0);
    check_output("fill.after_pop_level", W'(level), 3);
    check_output("fill.after_pop_head", word_out, w[1]);
    send_word(w[4], 1'b0);
    check_output("fill.refill_level", W'(level), 4);
    for (int k = 1; k <= 4; k++) begin
      check_output("fill.drain_order", word_out, w[k]);
      pop_one();
    end
    check_output("fill.drained_level", W'(level), 0);

    // Push and pop on the same edge at level 2.
    send_word(w[5], 1'b0);
    send_word(w[6], 1'b0);
    send_bits(w[7], W - 1, 1'b0);
    apply_stimulus(w[7][0], 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("simul.level", W'(level), 2);
    check_output("simul.head", word_out, w[6]);
    pop_one();
    check_output("simul.second", word_out, w[7]);
    pop_one();
    check_output("simul.empty", W'(word_valid), 0);

    // Permanent failure with three words and a 17-bit partial word.
    for (int k = 0; k < 3; k++) send_word(w[k], 1'b0);
    send_bits(w[8], 17, 1'b0);
    check_output("perm.level_before", W'(level), 3);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_output("perm.level", W'(level), 0);
    check_output("perm.word_valid", W'(word_valid), 0);
    check_output("perm.err", W'(err), 1);
    check_output("perm.full", W'(full), 1);
    send_bits(w[8], W, 1'b1);
    send_bits(w[2], 8, 1'b1);
    check_output("perm.ignored_level", W'(level), 0);
    check_output("perm.sticky_err", W'(err), 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reset_values("perm_rst");

    // bit_valid toggling: only the 32 valid-high bits form the word.
    toggle_word = 32'hC3C3_5AA5;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 1) apply_stimulus(toggle_word[W-1-(i/2)], 1'b1, 1'b0, 1'b0, 1'b0);
      else            apply_stimulus(~toggle_word[W-1-(i/2)], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_output("toggle.level", W'(level), 1);
    check_output("toggle.word", word_out, 32'hC3C3_5AA5);
    pop_one();

    // Reset in the middle of a word with two words buffered.
    send_word(w[0], 1'b0);
    send_word(w[1], 1'b0);
    send_bits(w[2], 10, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reset_values("midrst");
    send_word(32'h0BAD_F00D, 1'b0);
    check_output("midrst.clean_word", word_out, 32'h0BAD_F00D);
    check_output("midrst.clean_level", W'(level), 1);
    idle(2);

    checking_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
